// File: rtl/galois_mult_digit_serial_pkg.sv
// Shared state encoding, constants and helpers for the digit-serial GF(2^N) multiplier.
package galois_pkg;

  typedef enum logic [1:0] {
    GF_IDLE = 2'd0,
    GF_BUSY = 2'd1,
    GF_DONE = 2'd2
  } gf_state_t;

  localparam logic [8:0] AES_POLY = 9'h11B;

  function automatic int gf_ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/galois_mult_digit_serial_step.sv
// One digit step of the MSB-first multiplier: acc*x^D + a*digit, reduced mod p after every bit.
module galois_digit_step #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] a,
  input  logic [D-1:0] digit,
  input  logic [N-1:0] p,
  output logic [N-1:0] acc_next
);

  logic [N-1:0] stage_s;

  // Horner chain over the digit bits, MSB first; each pass is one mul-by-x and conditional add of a.
  always_comb begin
    stage_s = acc;
    for (int j = D - 1; j >= 0; j--) begin
      if (stage_s[N-1]) begin
        stage_s = {stage_s[N-2:0], 1'b0} ^ p;
      end else begin
        stage_s = {stage_s[N-2:0], 1'b0};
      end
      if (digit[j]) begin
        stage_s = stage_s ^ a;
      end else begin
        stage_s = stage_s;
      end
    end
    acc_next = stage_s;
  end

endmodule

// File: rtl/galois_mult_digit_serial.sv
// Sequential GF(2^N) multiplier consuming D bits of b per cycle, with valid/ready on both sides.
module galois_mult_digit_serial
  import galois_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N:0]   p,
  input  logic         op_sqr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s
);

  localparam int K  = gf_ceil_div(N, D);
  localparam int W  = K * D;
  localparam int CW = $clog2(K + 1);

  gf_state_t    state_r;
  gf_state_t    state_s;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  b_sh_r;
  logic [W-1:0]  b_load_s;
  logic [N-1:0]  a_r;
  logic [N-1:0]  p_r;
  logic [N-1:0]  acc_r;
  logic [N-1:0]  acc_next_s;
  logic [N-1:0]  s_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          accept_s;
  logic          p_msb_unused_s;

  // The leading coefficient of p is implicit in the reduction.
  assign p_msb_unused_s = p[N];
  assign accept_s       = in_valid && (state_r == GF_IDLE);

  galois_digit_step #(.N(N), .D(D)) u_step (
    .acc      (acc_r),
    .a        (a_r),
    .digit    (b_sh_r[W-1 -: D]),
    .p        (p_r),
    .acc_next (acc_next_s)
  );

  // Zero-pad the multiplier operand up to a whole number of digits.
  always_comb begin
    b_load_s = '0;
    if (op_sqr) begin
      b_load_s[N-1:0] = a;
    end else begin
      b_load_s[N-1:0] = b;
    end
  end

  // Next-state logic for the IDLE/BUSY/DONE handshake sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      GF_IDLE: begin
        if (in_valid) state_s = GF_BUSY;
        else          state_s = GF_IDLE;
      end
      GF_BUSY: begin
        if (cnt_r == '0) state_s = GF_DONE;
        else             state_s = GF_BUSY;
      end
      GF_DONE: begin
        if (out_ready) state_s = GF_IDLE;
        else           state_s = GF_DONE;
      end
      default: state_s = GF_IDLE;
    endcase
  end

  // State register with registered handshake outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= GF_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == GF_IDLE);
      out_valid_r <= (state_s == GF_DONE);
    end
  end

  // Operand latches, digit shifter, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      p_r    <= '0;
      b_sh_r <= '0;
      acc_r  <= '0;
      cnt_r  <= '0;
      s_r    <= '0;
    end else if (accept_s) begin
      a_r    <= a;
      p_r    <= p[N-1:0];
      b_sh_r <= b_load_s;
      acc_r  <= '0;
      cnt_r  <= CW'(K - 1);
    end else if (state_r == GF_BUSY) begin
      acc_r  <= acc_next_s;
      b_sh_r <= b_sh_r << D;
      if (cnt_r == '0) begin
        s_r   <= acc_next_s;
        cnt_r <= cnt_r;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;

endmodule

// File: tb/tb_galois_mult_digit_serial.sv
// Bench: five multiplier configurations share one stimulus stream; results scored against a product-then-reduce model.
module tb_galois_mult_digit_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        op_sqr = 1'b0;
  logic [7:0]  a8 = 8'h00;
  logic [7:0]  b8 = 8'h00;
  logic [8:0]  p9 = 9'h11B;
  logic [15:0] a16 = 16'h0000;
  logic [15:0] b16 = 16'h0000;
  logic [16:0] p17 = 17'h1002B;

  logic ir1, ir2, ir3, ir8, irw;
  logic ov1, ov2, ov3, ov8, ovw;
  logic [7:0]  s1, s2, s3, s8;
  logic [15:0] sw;

  typedef struct packed {
    logic [7:0]  e8;
    logic [15:0] e16;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  galois_mult_digit_serial #(.N(8), .D(1)) u_d1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a8), .b(b8), .p(p9), .op_sqr(op_sqr), .out_valid(ov1), .out_ready(out_ready), .s(s1));
  galois_mult_digit_serial #(.N(8), .D(2)) u_d2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .a(a8), .b(b8), .p(p9), .op_sqr(op_sqr), .out_valid(ov2), .out_ready(out_ready), .s(s2));
  galois_mult_digit_serial #(.N(8), .D(3)) u_d3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3),
    .a(a8), .b(b8), .p(p9), .op_sqr(op_sqr), .out_valid(ov3), .out_ready(out_ready), .s(s3));
  galois_mult_digit_serial #(.N(8), .D(8)) u_d8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .a(a8), .b(b8), .p(p9), .op_sqr(op_sqr), .out_valid(ov8), .out_ready(out_ready), .s(s8));
  galois_mult_digit_serial #(.N(16), .D(4)) u_w4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irw),
    .a(a16), .b(b16), .p(p17), .op_sqr(op_sqr), .out_valid(ovw), .out_ready(out_ready), .s(sw));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full carry-less product, then long division by the complete (N+1)-bit polynomial.
  function automatic logic [15:0] gf_ref(input int n, input logic [15:0] x, input logic [15:0] y,
                                         input logic [16:0] poly);
    logic [31:0] prod;
    prod = 32'h0;
    for (int i = 0; i < n; i++)
      if (y[i]) prod = prod ^ (32'(x) << i);
    for (int i = 2 * n - 2; i >= n; i--)
      if (prod[i]) prod = prod ^ (32'(poly) << (i - n));
    return prod[15:0];
  endfunction

  task automatic mon(input string tag, input logic ov, input logic [15:0] sv, input logic [15:0] ev,
                     input int lat, input int cyc, inout bit seen);
    if (ov && !seen) begin
      seen = 1'b1;
      check({tag, "_lat"}, 32'(cyc), 32'(lat));
      check({tag, "_val"}, 32'(sv), 32'(ev));
    end
  endtask

  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic [8:0] xp, input logic sq,
                       input logic [15:0] wa, input logic [15:0] wb, input logic [16:0] wp, input bit toggle);
    exp_t e;
    bit   seen [5];
    bit   popped;
    int   waited;
    e.e8  = gf_ref(8, {8'h00, xa}, sq ? {8'h00, xa} : {8'h00, xb}, {8'h00, xp});
    e.e16 = gf_ref(16, wa, sq ? wa : wb, wp);
    waited = 0;
    while (!(ir1 && ir2 && ir3 && ir8 && irw) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
    a8 = xa; b8 = xb; p9 = xp; op_sqr = sq; a16 = wa; b16 = wb; p17 = wp;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    popped = 1'b0;
    for (int i = 0; i < 5; i++) seen[i] = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (!popped && (ov1 || ov2 || ov3 || ov8 || ovw)) begin
        popped = 1'b1;
        if (exp_q.size() == 0) check("queue_empty", 32'd0, 32'd1);
        else cur = exp_q.pop_front();
      end
      mon("d1", ov1, {8'h00, s1}, {8'h00, cur.e8}, 8, cyc, seen[0]);
      mon("d2", ov2, {8'h00, s2}, {8'h00, cur.e8}, 4, cyc, seen[1]);
      mon("d3", ov3, {8'h00, s3}, {8'h00, cur.e8}, 3, cyc, seen[2]);
      mon("d8", ov8, {8'h00, s8}, {8'h00, cur.e8}, 1, cyc, seen[3]);
      mon("w4", ovw, sw, cur.e16, 4, cyc, seen[4]);
      if (toggle) begin
        a8 = 8'($urandom); b8 = 8'($urandom); p9 = 9'($urandom); op_sqr = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); p17 = 17'($urandom);
      end
    end
    for (int i = 0; i < 5; i++)
      if (!seen[i]) check($sformatf("no_result_%0d", i), 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ra, rb;
    logic [8:0]  rp;
    logic [15:0] wa, wb;
    logic [16:0] wp;
    logic        rs;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(ir1 & ir3 & ir8 & irw), 32'd1);
    check("rst_out_valid", 32'(ov1 | ov2 | ov3 | ov8 | ovw), 32'd0);
    check("rst_s", 32'({s1, s8} | sw), 32'd0);
    rst_n = 1'b1;

    // Directed known-answer vectors (AES field).
    do_op(8'h57, 8'h83, 9'h11B, 1'b0, 16'h1234, 16'h5678, 17'h1002B, 1'b0);
    check("kat_57x83", 32'(s1), 32'hC1);
    do_op(8'h53, 8'hCA, 9'h11B, 1'b0, 16'hFFFF, 16'h8001, 17'h1002B, 1'b0);
    check("kat_53xCA", 32'(s3), 32'h01);
    do_op(8'h80, 8'hFF, 9'h11B, 1'b1, 16'h8000, 16'hFFFF, 17'h1002B, 1'b0);
    check("sqr_80", 32'(s8), 32'h9A);
    do_op(8'h02, 8'hFF, 9'h11B, 1'b1, 16'h0002, 16'h0000, 17'h1002B, 1'b0);
    check("sqr_02", 32'(s1), 32'h04);

    // Backpressure in DONE, with a new request presented that must wait.
    repeat (12) @(posedge clk);
    @(negedge clk);
    a8 = 8'h57; b8 = 8'h83; p9 = 9'h11B; op_sqr = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("bp_ov", 32'(ov1), 32'd1);
    check("bp_s", 32'(s1), 32'hC1);
    in_valid = 1'b1; a8 = 8'h53; b8 = 8'hCA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ov", 32'(ov1), 32'd1);
      check("bp_hold_s", 32'(s1), 32'hC1);
      check("bp_in_ready", 32'(ir1), 32'd0);
      check("bp_hold_s8", 32'(s8), 32'hC1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ir", 32'(ir1), 32'd1);
    check("bp_release_ov", 32'(ov1), 32'd0);
    check("bp_s_held", 32'(s1), 32'hC1);
    @(posedge clk); #1;
    check("bp_next_accept", 32'(ir1), 32'd0);
    in_valid = 1'b0;
    repeat (7) @(posedge clk); #1;
    check("bp_next_early", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    check("bp_next_ov", 32'(ov1), 32'd1);
    check("bp_next_s", 32'(s1), 32'h01);

    // Reset during the fourth BUSY cycle.
    repeat (4) @(posedge clk);
    @(negedge clk);
    a8 = 8'h57; b8 = 8'h83; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(ov1), 32'd0);
    check("mid_rst_ir", 32'(ir1), 32'd1);
    check("mid_rst_s", 32'({s1, s8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("post_rst_ov", 32'(ov1), 32'd0);
    do_op(8'h57, 8'h83, 9'h11B, 1'b0, 16'h0001, 16'h0001, 17'h1002B, 1'b0);
    check("post_rst_kat", 32'(s1), 32'hC1);

    // Random operations with inputs scrambled while the operation is in flight.
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 3) == 0);
      rp = (n % 2 == 0) ? 9'h11B : {1'b1, 8'($urandom)};
      wa = 16'($urandom); wb = 16'($urandom);
      wp = (n % 2 == 0) ? 17'h1002B : {1'b1, 16'($urandom)};
      do_op(ra, rb, rp, rs, wa, wb, wp, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
